// File: rtl/prefix_merge_pkg.sv
// Shared definitions for the prefix merge stage that sits behind the
// instruction decoder: opcode values, micro-op kind encoding, the pending-
// prefix FSM encoding, the registered micro-op record and the immediate
// sign-extension helper.
package prefix_merge_pkg;

  localparam int IMM_W   = 32;
  localparam int TA_W    = 6;
  localparam int IMMLO_W = 6;
  localparam int IMMHI_W = IMM_W - IMMLO_W;  // width carried by an I-prefix
  localparam int NTGT    = 4;

  // Decoder opcodes
  localparam logic [2:0] OP_ALU   = 3'b000;  // D-format ALU
  localparam logic [2:0] OP_LOAD  = 3'b001;  // D-format load
  localparam logic [2:0] OP_STORE = 3'b010;  // W-format store (one target)
  localparam logic [2:0] OP_TPFX  = 3'b011;  // target prefix (ta3/ta4)
  localparam logic [2:0] OP_IPFX  = 3'b100;  // immediate prefix (immhi)
  localparam logic [2:0] OP_FRAG  = 3'b101;  // fragment marker

  typedef enum logic [1:0] {
    KIND_ALU   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_FRAG  = 2'd3
  } kind_t;

  // Which prefixes are currently held waiting for an instruction
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T    = 2'd1,
    ST_I    = 2'd2,
    ST_TI   = 2'd3
  } state_t;

  typedef struct packed {
    kind_t                 kind;
    logic [3:0]            funct;
    logic                  immab;
    logic [IMM_W-1:0]      imm;
    logic [9:0]            offset;
    logic [NTGT*TA_W-1:0]  ta;      // {ta4,ta3,ta2,ta1}
    logic [2*NTGT-1:0]     tt;      // {tt4,tt3,tt2,tt1}
    logic [2:0]            ntgt;
    logic [5:0]            nalloc;
    logic                  endf;
  } uop_t;

  function automatic logic [IMM_W-1:0] sext_immlo(input logic [IMMLO_W-1:0] lo);
    return {{IMMHI_W{lo[IMMLO_W-1]}}, lo};
  endfunction

endpackage

// File: rtl/prefix_merge_if.sv
// Decoder-to-merge-to-backend bundle.
//   Input side : in_valid/in_ready handshake plus the decoder field bundle
//                (op, funct, nalloc, endF, immab, immlo, immhi, offset,
//                ta1..ta4, tt1..tt4).
//   Output side: out_valid/out_ready handshake plus the fused micro-op
//                (out_kind, out_funct, out_immab, out_imm, out_offset,
//                out_ta, out_tt, out_ntgt, out_nalloc, out_endF) and err.
// slave  : the merge stage itself.
// master : the surrounding environment (decoder + backend).
interface prefix_merge_if;
  import prefix_merge_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           op;
  logic [3:0]           funct;
  logic [5:0]           nalloc;
  logic                 endF;
  logic                 immab;
  logic [IMMLO_W-1:0]   immlo;
  logic [IMMHI_W-1:0]   immhi;
  logic [9:0]           offset;
  logic [TA_W-1:0]      ta1, ta2, ta3, ta4;
  logic [1:0]           tt1, tt2, tt3, tt4;

  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_kind;
  logic [3:0]           out_funct;
  logic                 out_immab;
  logic [IMM_W-1:0]     out_imm;
  logic [9:0]           out_offset;
  logic [NTGT*TA_W-1:0] out_ta;
  logic [2*NTGT-1:0]    out_tt;
  logic [2:0]           out_ntgt;
  logic [5:0]           out_nalloc;
  logic                 out_endF;
  logic                 err;

  modport slave (
    input  in_valid, op, funct, nalloc, endF, immab, immlo, immhi, offset,
           ta1, ta2, ta3, ta4, tt1, tt2, tt3, tt4, out_ready,
    output in_ready, out_valid, out_kind, out_funct, out_immab, out_imm,
           out_offset, out_ta, out_tt, out_ntgt, out_nalloc, out_endF, err
  );

  modport master (
    output in_valid, op, funct, nalloc, endF, immab, immlo, immhi, offset,
           ta1, ta2, ta3, ta4, tt1, tt2, tt3, tt4, out_ready,
    input  in_ready, out_valid, out_kind, out_funct, out_immab, out_imm,
           out_offset, out_ta, out_tt, out_ntgt, out_nalloc, out_endF, err
  );

endinterface

// File: rtl/prefix_merge.sv
// Prefix merge stage. Absorbs T-prefix (extra targets) and I-prefix (upper
// immediate) words from the decoder and fuses them into the next ALU/LOAD/
// STORE instruction, producing one registered micro-op. Fragment markers
// pass through as FRAG records; invalid opcodes and duplicate or orphaned
// prefixes raise a one-cycle err pulse.
//
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  prefix_merge_if.slave (decoder bundle in, micro-op out, err)
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | no prefix pending
// ST_T    | T-prefix pending (ta3/tt3, ta4/tt4 saved)
// ST_I    | I-prefix pending (immhi saved)
// ST_TI   | both prefixes pending
module prefix_merge
  import prefix_merge_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  prefix_merge_if.slave bus
);

  state_t state_q, state_d;

  logic               t_pend, i_pend;
  logic [TA_W-1:0]    pfx_ta3_q, pfx_ta4_q;
  logic [1:0]         pfx_tt3_q, pfx_tt4_q;
  logic [IMMHI_W-1:0] pfx_immhi_q;

  logic out_valid_q;
  uop_t uop_q, uop_d;
  logic err_q, err_d;

  logic in_ready;
  logic accept;
  logic load_t, load_i, load_out, clr_pfx;

  // One-entry output register: a new bundle may be taken whenever the slot
  // is empty or is being drained this very cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign t_pend = (state_q == ST_T) || (state_q == ST_TI);
  assign i_pend = (state_q == ST_I) || (state_q == ST_TI);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (bus.op)
        OP_TPFX: state_d = i_pend ? ST_TI : ST_T;
        OP_IPFX: state_d = t_pend ? ST_TI : ST_I;
        default: state_d = ST_IDLE;  // instruction, fragment or invalid op
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    err_d    = 1'b0;
    load_t   = 1'b0;
    load_i   = 1'b0;
    load_out = 1'b0;
    clr_pfx  = 1'b0;
    uop_d    = '0;
    if (accept) begin
      unique case (bus.op)
        OP_TPFX: begin
          load_t = 1'b1;
          err_d  = t_pend;   // newer prefix overwrites the older one
        end
        OP_IPFX: begin
          load_i = 1'b1;
          err_d  = i_pend;
        end
        OP_ALU, OP_LOAD, OP_STORE: begin
          load_out    = 1'b1;
          clr_pfx     = 1'b1;
          uop_d.kind  = (bus.op == OP_ALU)  ? KIND_ALU  :
                        (bus.op == OP_LOAD) ? KIND_LOAD : KIND_STORE;
          uop_d.funct = bus.funct;
          uop_d.immab = bus.immab;
          uop_d.imm   = i_pend ? {pfx_immhi_q, bus.immlo} : sext_immlo(bus.immlo);
          uop_d.ta[TA_W-1:0] = bus.ta1;
          uop_d.tt[1:0]      = bus.tt1;
          uop_d.ntgt         = 3'd1;
          // W-format stores carry a single target; slot 2 stays zero
          if (bus.op != OP_STORE) begin
            uop_d.ta[2*TA_W-1:TA_W] = bus.ta2;
            uop_d.tt[3:2]           = bus.tt2;
            uop_d.ntgt              = 3'd2;
          end
          if (t_pend) begin
            uop_d.ta[4*TA_W-1:2*TA_W] = {pfx_ta4_q, pfx_ta3_q};
            uop_d.tt[7:4]             = {pfx_tt4_q, pfx_tt3_q};
            uop_d.ntgt                = uop_d.ntgt + 3'd2;
          end
          if (bus.op == OP_STORE) uop_d.offset = bus.offset;
        end
        OP_FRAG: begin
          load_out     = 1'b1;
          clr_pfx      = 1'b1;
          err_d        = t_pend || i_pend;  // prefix cannot cross a fragment
          uop_d.kind   = KIND_FRAG;
          uop_d.nalloc = bus.nalloc;
          uop_d.endf   = bus.endF;
        end
        default: begin
          clr_pfx = 1'b1;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------- prefix registers
  always_ff @(posedge clk) begin
    if (rst || clr_pfx) begin
      pfx_ta3_q   <= '0;
      pfx_ta4_q   <= '0;
      pfx_tt3_q   <= '0;
      pfx_tt4_q   <= '0;
      pfx_immhi_q <= '0;
    end else begin
      if (load_t) begin
        pfx_ta3_q <= bus.ta3;
        pfx_ta4_q <= bus.ta4;
        pfx_tt3_q <= bus.tt3;
        pfx_tt4_q <= bus.tt4;
      end
      if (load_i) pfx_immhi_q <= bus.immhi;
    end
  end

  // ---------------------------------------------------------- output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      uop_q       <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      uop_q       <= uop_d;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_kind   = uop_q.kind;
  assign bus.out_funct  = uop_q.funct;
  assign bus.out_immab  = uop_q.immab;
  assign bus.out_imm    = uop_q.imm;
  assign bus.out_offset = uop_q.offset;
  assign bus.out_ta     = uop_q.ta;
  assign bus.out_tt     = uop_q.tt;
  assign bus.out_ntgt   = uop_q.ntgt;
  assign bus.out_nalloc = uop_q.nalloc;
  assign bus.out_endF   = uop_q.endf;
  assign bus.err        = err_q;

endmodule
